pc_unit: RTL and testbench

Parametrised program-counter unit for the RV32I fetch stage. It generalises the combinational `pc + immExt` adder into a registered PC with sequential increment, branch/JAL/JALR target selection, stall hold and a one-entry pending-redirect buffer. The buffer captures a redirect that arrives during a stall. Sits between the execute-stage branch resolution and the instruction-memory address port.

---
 rtl/pc_if.sv | 15 +
 rtl/pc_unit.sv | 57 +++++
 tb/tb_pc_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/pc_if.sv
// pc_if: redirect inputs from execute and fetch-address outputs of pc_unit.
interface pc_if #(parameter int XLEN = 32);
  logic stall, br_taken, jal, jalr;
  logic [XLEN-1:0] pc_src, imm_ext, rs1_val;
  logic [XLEN-1:0] pc, pc_next_seq, link_addr;
  logic pc_valid, redirect_pending, misaligned;
  modport master (
    output stall, br_taken, jal, jalr, pc_src, imm_ext, rs1_val,
    input  pc, pc_next_seq, link_addr, pc_valid, redirect_pending, misaligned
  );
  modport slave (
    input  stall, br_taken, jal, jalr, pc_src, imm_ext, rs1_val,
    output pc, pc_next_seq, link_addr, pc_valid, redirect_pending, misaligned
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: registered fetch PC with branch/JAL/JALR redirect, stall hold and one-entry pending-redirect buffer.
// Optional misaligned-target trap: define PC_MISALIGN_TRAP_EN.
module pc_unit #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int INSTR_BYTES = 4
) (
  input logic clk,
  input logic rst,
  pc_if.slave bus
);
  localparam logic [XLEN-1:0] INC = XLEN'(INSTR_BYTES);
  typedef enum logic {EMPTY, FULL} buf_state_t;
  buf_state_t state;
  logic [XLEN-1:0] pc, buf_tgt, jalr_sum, tgt;
  logic req, bad, valid;
  always_comb begin
    jalr_sum = bus.rs1_val + bus.imm_ext;
    tgt = bus.jalr ? (jalr_sum & ~XLEN'(1)) : bus.pc_src + bus.imm_ext;
    req = bus.jalr | bus.jal | bus.br_taken;
  end
`ifdef PC_MISALIGN_TRAP_EN
  logic mis;
  assign bad = req && ((tgt % INC) != '0);
  assign bus.misaligned = mis;
  always_ff @(posedge clk) mis <= !rst && bad;
`else
  assign bad = 1'b0;
  assign bus.misaligned = 1'b0;
`endif
  // a rejected (misaligned) request matches no branch, so pc and buffer hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      valid <= 1'b0;
      state <= EMPTY;
      buf_tgt <= '0;
    end else begin
      valid <= 1'b1;
      if (req && !bad && !bus.stall) begin
        pc <= tgt;
        state <= EMPTY;
      end else if (req && !bad) begin
        buf_tgt <= tgt;
        state <= FULL;
      end else if (!req && state == FULL && !bus.stall) begin
        pc <= buf_tgt;
        state <= EMPTY;
      end else if (!req && !bus.stall) pc <= pc + INC;
    end
  end
  assign bus.pc = pc;
  assign bus.pc_next_seq = pc + INC;
  assign bus.link_addr = bus.pc_src + INC;
  assign bus.pc_valid = valid;
  assign bus.redirect_pending = state == FULL;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: scoreboard bench; driver pushes model expectations, monitor pops and compares each cycle.
module tb_pc_unit;
  localparam int XLEN = 32;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  pc_if #(.XLEN(XLEN)) bus();
  pc_unit #(.XLEN(XLEN), .RESET_PC(32'h0), .INSTR_BYTES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [31:0] pc, seq, link;
    logic valid, pend, mis;
  } exp_t;
  exp_t q[$];
  int errors = 0, checks = 0;
  bit [31:0] m_pc, m_buf;
  bit m_valid, m_pend, m_mis;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc", bus.pc, e.pc);
      chk("pc_next_seq", bus.pc_next_seq, e.seq);
      chk("link_addr", bus.link_addr, e.link);
      chk("pc_valid", 32'(bus.pc_valid), 32'(e.valid));
      chk("redirect_pending", 32'(bus.redirect_pending), 32'(e.pend));
      chk("misaligned", 32'(bus.misaligned), 32'(e.mis));
    end
  end
  task automatic cyc(input bit r, input bit s, input bit b, input bit j, input bit jr,
                     input bit [31:0] src, input bit [31:0] imm, input bit [31:0] rs1);
    bit [31:0] t, sum;
    bit req, bad;
    exp_t e;
    rst = r; bus.stall = s; bus.br_taken = b; bus.jal = j; bus.jalr = jr;
    bus.pc_src = src; bus.imm_ext = imm; bus.rs1_val = rs1;
    req = b | j | jr;
    sum = rs1 + imm;
    t = jr ? sum - (sum % 2) : src + imm;
`ifdef PC_MISALIGN_TRAP_EN
    bad = req && (t % 4 != 0);
`else
    bad = 1'b0;
`endif
    m_mis = 1'b0;
    if (r) begin
      m_pc = 32'h0; m_valid = 1'b0; m_pend = 1'b0;
    end else begin
      m_valid = 1'b1;
      if (bad) m_mis = 1'b1;
      else if (req && !s) begin m_pc = t; m_pend = 1'b0; end
      else if (req) begin m_buf = t; m_pend = 1'b1; end
      else if (m_pend && !s) begin m_pc = m_buf; m_pend = 1'b0; end
      else if (!s) m_pc = m_pc + 4;
    end
    e.pc = m_pc; e.seq = m_pc + 4; e.link = src + 4;
    e.valid = m_valid; e.pend = m_pend; e.mis = m_mis;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask
  initial begin
    bit [31:0] imm;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 32'h10, 32'hFFFF_FFFC, 0);
    cyc(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h8, 0);
    cyc(0, 0, 1, 1, 1, 32'h200, 32'h0, 32'h101);
    cyc(0, 1, 0, 1, 0, 32'h40, 32'h0, 0);
    cyc(0, 1, 1, 0, 0, 32'h80, 32'h0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 32'h40, 32'h0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 32'h20, 32'h2, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 32'h30, 32'h3, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      imm = $urandom_range(0, 7) == 0 ? $urandom : $urandom & 32'hFFFF_FFFC;
      cyc($urandom_range(0, 49) == 0, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
          $urandom & 32'hFFFF_FFFC, imm, $urandom);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
